// File: rtl/eth_mac_filter.sv
// Destination-MAC filter for the Ethernet receive path.
// Holds each frame's header in a small FIFO until the address decision is known.
// Accepted frames are forwarded byte-for-byte; rejected frames are discarded.
// Saturating accept/drop statistics are kept.
module eth_mac_filter #(
    parameter int N_ADDR     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_sof,
    input  logic              in_eof,
    input  logic              cfg_we,
    input  logic [5:0]        cfg_addr,
    input  logic [7:0]        cfg_data,
    input  logic [N_ADDR-1:0] cfg_en,
    input  logic              accept_bcast,
    input  logic              accept_mcast,
    input  logic              promisc,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic              out_sof,
    output logic              out_eof,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stat_accept_cnt,
    output logic [CNT_W-1:0]  stat_drop_cnt,
    output logic              busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_PASS, S_DRAIN, S_DISCARD} state_t;

    state_t            state_q, state_d;
    // Bytes 6/7 of each entry are never written and stay zero; they only
    // keep the byte-counter index in range.
    logic [7:0]        tbl_q [N_ADDR][8];
    logic [7:0]        tbl_d [N_ADDR][8];
    logic [N_ADDR-1:0] flag_q, flag_d, flag_nx;
    logic              bcast_q, bcast_d, bcast_nx;
    logic              mcast_q, mcast_d, mcast_nx;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       fill_q, fill_d;
    logic              out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eof_q, out_eof_d;
    logic [7:0]        out_data_q, out_data_d;
    logic [CNT_W-1:0]  acc_q, acc_d, drop_q, drop_d;
    logic              push, pop, flush, acc_inc, drop_inc, accept_now;
    logic              fifo_full, fifo_empty;

    assign fifo_full  = (fill_q == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (fill_q == '0);

    // Match flags updated with the current byte, and the resulting decision.
    always_comb begin
        for (int i = 0; i < N_ADDR; i++) begin
            flag_nx[i] = flag_q[i] & (in_data == tbl_q[i][cnt_q]);
        end
        bcast_nx   = bcast_q & (in_data == 8'hFF);
        mcast_nx   = (cnt_q == 3'd0) ? in_data[0] : mcast_q;
        accept_now = promisc | (bcast_nx & accept_bcast) |
                     (mcast_nx & ~bcast_nx & accept_mcast) | (|(flag_nx & cfg_en));
    end

    // MAC table writes; unused byte slots and absent entries are ignored.
    always_comb begin
        tbl_d = tbl_q;
        for (int i = 0; i < N_ADDR; i++) begin
            for (int b = 0; b < 6; b++) begin
                if (cfg_we && cfg_addr[5:3] == 3'(i) && cfg_addr[2:0] == 3'(b)) begin
                    tbl_d[i][b] = cfg_data;
                end
            end
        end
    end

    // Frame state machine, FIFO control and statistics next-state.
    always_comb begin
        state_d     = state_q;
        flag_d      = flag_q;
        bcast_d     = bcast_q;
        mcast_d     = mcast_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_sof_d   = 1'b0;
        out_eof_d   = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        flush       = 1'b0;
        acc_inc     = 1'b0;
        drop_inc    = 1'b0;

        if (in_sof) begin
            // A new frame start always restarts parsing; an unfinished frame is a drop.
            drop_inc = (state_q != S_IDLE);
            state_d  = S_ADDR;
            flush    = 1'b1;
            flag_d   = '1;
            bcast_d  = 1'b1;
            mcast_d  = 1'b0;
            cnt_d    = 3'd0;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_ADDR: begin
                    if (in_valid) begin
                        push    = 1'b1;
                        flag_d  = flag_nx;
                        bcast_d = bcast_nx;
                        mcast_d = mcast_nx;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd5) begin
                            if (accept_now) begin
                                out_sof_d = 1'b1;
                                state_d   = in_eof ? S_DRAIN : S_PASS;
                            end else begin
                                flush    = 1'b1;
                                drop_inc = in_eof;
                                state_d  = in_eof ? S_IDLE : S_DISCARD;
                            end
                        end else if (in_eof) begin
                            drop_inc = 1'b1;
                            state_d  = S_IDLE;
                        end
                    end else if (in_eof) begin
                        drop_inc = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                S_PASS: begin
                    if (in_valid && fifo_full) begin
                        // Overflow: abandon the frame without an end marker.
                        flush    = 1'b1;
                        drop_inc = in_eof;
                        state_d  = in_eof ? S_IDLE : S_DISCARD;
                    end else begin
                        pop  = !fifo_empty;
                        push = in_valid;
                        if (in_eof) state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        out_eof_d = 1'b1;
                        acc_inc   = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if (in_eof) begin
                        drop_inc = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = mem[rd_ptr_q];
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      fill_d = fill_q + (AW+1)'(1);
            else if (!push && pop) fill_d = fill_q - (AW+1)'(1);
        end

        // Clear wins over increment; counters stick at all-ones.
        if (stat_clr)                 acc_d = '0;
        else if (acc_inc && ~&acc_q)  acc_d = acc_q + CNT_W'(1);
        else                          acc_d = acc_q;
        if (stat_clr)                 drop_d = '0;
        else if (drop_inc && ~&drop_q) drop_d = drop_q + CNT_W'(1);
        else                          drop_d = drop_q;
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_q] <= in_data;
    end

    // State, table, pointers, registered outputs and counters.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            flag_q      <= '0;
            bcast_q     <= 1'b0;
            mcast_q     <= 1'b0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            acc_q       <= '0;
            drop_q      <= '0;
            for (int i = 0; i < N_ADDR; i++) begin
                for (int b = 0; b < 8; b++) tbl_q[i][b] <= '0;
            end
        end else begin
            state_q     <= state_d;
            flag_q      <= flag_d;
            bcast_q     <= bcast_d;
            mcast_q     <= mcast_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            acc_q       <= acc_d;
            drop_q      <= drop_d;
            tbl_q       <= tbl_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign out_sof         = out_sof_q;
    assign out_eof         = out_eof_q;
    assign stat_accept_cnt = acc_q;
    assign stat_drop_cnt   = drop_q;
    assign busy            = (state_q != S_IDLE);
endmodule

// File: tb/tb_eth_mac_filter.sv
// Directed testbench for eth_mac_filter: a 16-bit-counter instance carries
// the functional checks, a 2-bit-counter instance sharing its inputs checks
// counter saturation.
module tb_eth_mac_filter;
    localparam logic [47:0] MAC1 = 48'h02005E102030;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        cfg_we = 1'b0;
    logic [5:0]  cfg_addr = 6'h00;
    logic [7:0]  cfg_data = 8'h00;
    logic [3:0]  cfg_en = 4'b0000;
    logic        accept_bcast = 1'b0, accept_mcast = 1'b0, promisc = 1'b0, stat_clr = 1'b0;
    logic        out_valid, out_sof, out_eof, busy;
    logic [7:0]  out_data;
    logic [15:0] acc_cnt, drop_cnt;
    logic        o2_valid, o2_sof, o2_eof, busy2;
    logic [7:0]  o2_data;
    logic [1:0]  acc2, drop2;

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    logic [7:0] fr [16];
    logic [7:0] cap [256];
    int ncap = 0, nsof = 0, neof = 0;
    int sof_cyc = 0, first_ov_cyc = 0, last_ov_cyc = 0, eof_cyc = 0;
    bit want_first = 1'b0;
    int base, s0, e0;

    eth_mac_filter #(.N_ADDR(4), .FIFO_DEPTH(8), .CNT_W(16)) dut (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
        .in_eof(in_eof), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_en(cfg_en), .accept_bcast(accept_bcast), .accept_mcast(accept_mcast),
        .promisc(promisc), .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof),
        .out_eof(out_eof), .stat_clr(stat_clr), .stat_accept_cnt(acc_cnt),
        .stat_drop_cnt(drop_cnt), .busy(busy));

    eth_mac_filter #(.N_ADDR(4), .FIFO_DEPTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
        .in_eof(in_eof), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_en(cfg_en), .accept_bcast(accept_bcast), .accept_mcast(accept_mcast),
        .promisc(promisc), .out_valid(o2_valid), .out_data(o2_data), .out_sof(o2_sof),
        .out_eof(o2_eof), .stat_clr(stat_clr), .stat_accept_cnt(acc2),
        .stat_drop_cnt(drop2), .busy(busy2));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records forwarded bytes and marker timing.
    always @(negedge clk) begin
        if (out_valid) begin
            cap[ncap % 256] = out_data;
            ncap++;
            last_ov_cyc = cyc;
            if (want_first) begin
                first_ov_cyc = cyc;
                want_first = 1'b0;
            end
        end
        if (out_sof) begin
            nsof++;
            sof_cyc = cyc;
            want_first = 1'b1;
        end
        if (out_eof) begin
            neof++;
            eof_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input logic [127:0] v, input int n);
        for (int i = 0; i < n; i++) fr[i] = v[8*(n-1-i) +: 8];
    endtask

    task automatic send_bytes(input int from, input int to);
        for (int i = from; i < to; i++) begin
            in_valid = 1'b1;
            in_data  = fr[i];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic send_sof();
        in_sof = 1'b1;
        tick();
        in_sof = 1'b0;
    endtask

    task automatic send_eof();
        in_eof = 1'b1;
        tick();
        in_eof = 1'b0;
    endtask

    task automatic frame(input int n);
        send_sof();
        send_bytes(0, n);
        send_eof();
        repeat (12) tick();
    endtask

    task automatic wr_entry(input int e, input logic [47:0] mac);
        for (int b = 0; b < 6; b++) begin
            cfg_we   = 1'b1;
            cfg_addr = {3'(e), 3'(b)};
            cfg_data = mac[8*(5-b) +: 8];
            tick();
        end
        cfg_we = 1'b0;
    endtask

    task automatic clr();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
    endtask

    task automatic mark();
        base = ncap;
        s0   = nsof;
        e0   = neof;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sof", out_sof, 0);
        check("rst_out_eof", out_eof, 0);
        check("rst_busy", busy, 0);
        check("rst_acc", acc_cnt, 0);
        check("rst_drop", drop_cnt, 0);
        n_rst = 1'b1;
        tick();

        // Unicast match on entry 1
        wr_entry(1, MAC1);
        cfg_en = 4'b0010;
        clr();
        mark();
        set_frame(80'h02005E102030AA557387, 10);
        send_sof();
        send_bytes(0, 6);
        check("t1_sof_after_6th", out_sof, 1);
        check("t1_no_ov_yet", out_valid, 0);
        send_bytes(6, 7);
        check("t1_first_ov", out_valid, 1);
        check("t1_first_data", out_data, 8'h02);
        send_bytes(7, 10);
        send_eof();
        repeat (12) tick();
        for (int i = 0; i < 10; i++) check($sformatf("t1_byte%0d", i), cap[(base+i)%256], fr[i]);
        check("t1_nbytes", ncap - base, 10);
        check("t1_nsof", nsof - s0, 1);
        check("t1_neof", neof - e0, 1);
        check("t1_sof_lead", first_ov_cyc - sof_cyc, 1);
        check("t1_eof_lag", eof_cyc - last_ov_cyc, 1);
        check("t1_acc", acc_cnt, 1);
        check("t1_drop", drop_cnt, 0);
        check("t1_busy", busy, 0);

        // Mismatching destination
        clr();
        mark();
        set_frame(80'hFAFAF6F2EEEAAA557387, 10);
        send_sof();
        send_bytes(0, 10);
        check("t2_busy_discard", busy, 1);
        send_eof();
        check("t2_busy_after_eof", busy, 0);
        check("t2_drop", drop_cnt, 1);
        repeat (12) tick();
        check("t2_nbytes", ncap - base, 0);
        check("t2_nsof", nsof - s0, 0);
        check("t2_neof", neof - e0, 0);
        check("t2_acc", acc_cnt, 0);

        // Broadcast and multicast
        clr();
        mark();
        set_frame(64'hFFFFFFFFFFFF1234, 8);
        frame(8);
        check("t3_bcast_off", ncap - base, 0);
        accept_bcast = 1'b1;
        mark();
        frame(8);
        check("t3_bcast_on", ncap - base, 8);
        check("t3_bcast_last", cap[(base+7)%256], 8'h34);
        accept_bcast = 1'b0;
        accept_mcast = 1'b1;
        mark();
        frame(8);
        check("t3_bcast_mcast_only", ncap - base, 0);
        set_frame(64'h01005E0000015A5A, 8);
        mark();
        frame(8);
        check("t3_mcast_fwd", ncap - base, 8);
        check("t3_mcast_first", cap[base%256], 8'h01);
        check("t3_acc", acc_cnt, 2);
        check("t3_drop", drop_cnt, 2);
        accept_mcast = 1'b0;

        // Runt frame with matching prefix
        clr();
        mark();
        set_frame(32'h02005E10, 4);
        frame(4);
        check("t4_runt_bytes", ncap - base, 0);
        check("t4_runt_drop", drop_cnt, 1);
        check("t4_runt_busy", busy, 0);

        // Aborted accepted frame followed by a complete one
        clr();
        mark();
        set_frame(80'h02005E102030AA557387, 10);
        send_sof();
        send_bytes(0, 8);
        send_sof();
        send_bytes(0, 10);
        send_eof();
        repeat (12) tick();
        check("t4_abort_nsof", nsof - s0, 2);
        check("t4_abort_neof", neof - e0, 1);
        check("t4_abort_nbytes", ncap - base, 12);
        check("t4_abort_b0", cap[base%256], 8'h02);
        check("t4_abort_b1", cap[(base+1)%256], 8'h00);
        check("t4_second_first", cap[(base+2)%256], 8'h02);
        check("t4_second_last", cap[(base+11)%256], 8'h87);
        check("t4_abort_drop", drop_cnt, 1);
        check("t4_abort_acc", acc_cnt, 1);

        // Promiscuous mode
        promisc = 1'b1;
        cfg_en  = 4'b0000;
        clr();
        mark();
        set_frame(56'h11223344556677, 7);
        frame(7);
        check("t5_nbytes", ncap - base, 7);
        for (int i = 0; i < 7; i++) check($sformatf("t5_byte%0d", i), cap[(base+i)%256], fr[i]);
        check("t5_acc", acc_cnt, 1);
        promisc = 1'b0;
        cfg_en  = 4'b0010;

        // Saturation on the 2-bit counters, zero-length frames
        clr();
        for (int k = 0; k < 5; k++) begin
            send_sof();
            send_eof();
            tick();
        end
        check("t6_drop2_sat", drop2, 3);
        check("t6_drop16", drop_cnt, 5);
        check("t6_acc2", acc2, 0);
        send_sof();
        in_eof   = 1'b1;
        stat_clr = 1'b1;
        tick();
        in_eof   = 1'b0;
        stat_clr = 1'b0;
        check("t6_clr_prio2", drop2, 0);
        check("t6_clr_prio16", drop_cnt, 0);
        send_sof();
        send_eof();
        check("t6_count_again", drop2, 1);

        // Reset in the middle of a forwarded frame
        clr();
        set_frame(80'h02005E102030AA557387, 10);
        frame(10);
        check("t7_acc_before", acc_cnt, 1);
        send_sof();
        send_bytes(0, 8);
        check("t7_ov_before", out_valid, 1);
        n_rst = 1'b0;
        #2;
        check("t7_rst_ov", out_valid, 0);
        check("t7_rst_data", out_data, 0);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_acc", acc_cnt, 0);
        tick();
        n_rst = 1'b1;
        tick();
        mark();
        frame(10);
        check("t7_table_cleared", ncap - base, 0);
        check("t7_drop_after", drop_cnt, 1);
        wr_entry(1, MAC1);
        mark();
        frame(10);
        check("t7_refwd_bytes", ncap - base, 10);
        check("t7_refwd_last", cap[(base+9)%256], 8'h87);
        check("t7_refwd_eof", neof - e0, 1);
        check("t7_acc_after", acc_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
